wt_mem_req_arbiter: RTL
=======================

# wt_mem_req_arbiter

Arbitrates instruction-cache refills and write-through data-cache requests onto the single shared memory request channel of the cv32a6 FPGA core, ahead of the AXI adapter. It provides round-robin fairness, a one-entry registered output slot, throttling of data-cache stores to a fixed outstanding-store budget, and response demultiplexing back to the originating cache. Its outstanding-store count and idle flag feed fence and AMO sequencing.

## Interface
- PLEN, 34: physical address width (Sv32).
- TidWidth, 2: transaction ID width (memory TID).
- MaxOutstandingStores, 7: maximum number of unacknowledged stores.
- CntWidth, $clog2(MaxOutstandingStores+1): width of the store counter (derived, not overridable).

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- icache_req_valid_i / icache_req_ready_o  in/out  1  icache refill handshake
- icache_req_addr_i  in  PLEN  refill address
- icache_req_tid_i  in  TidWidth  refill TID
- dcache_req_valid_i / dcache_req_ready_o  in/out  1  dcache handshake
- dcache_req_is_store_i  in  1  1 = store, 0 = load
- dcache_req_addr_i  in  PLEN  address
- dcache_req_wdata_i  in  64  store data
- dcache_req_tid_i  in  TidWidth  TID
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake
- mem_req_src_o  out  1  0 = icache, 1 = dcache
- mem_req_is_store_o  out  1  store flag
- mem_req_addr_o  out  PLEN  address
- mem_req_wdata_o  out  64  store data (0 for icache)
- mem_req_tid_o  out  TidWidth  TID
- mem_rsp_valid_i, mem_rsp_src_i, mem_rsp_is_store_i  in  1  response valid/source/store ack
- mem_rsp_tid_i  in  TidWidth;  mem_rsp_data_i  in  128  response TID / line data
- icache_rsp_valid_o  out  1;  icache_rsp_tid_o  out  TidWidth;  icache_rsp_data_o  out  128
- dcache_rsp_valid_o  out  1;  dcache_rsp_is_store_o  out  1;  dcache_rsp_tid_o  out  TidWidth;  dcache_rsp_data_o  out  128
- outstanding_stores_o  out  CntWidth  stores issued and not yet acknowledged
- stores_idle_o  out  1  outstanding_stores_o == 0 and no store in the slot
- stall_cycles_o  out  32  perf counter (see Configuration)

## Operation
- The output slot is one register: valid_q plus payload. mem_req_* are driven directly from the slot.
- The slot can accept when `!valid_q || mem_req_ready_i`.
- Eligibility: icache is eligible when its valid is high. dcache is eligible when its valid is high and (`!is_store` or count < MaxOutstandingStores).
- Round robin: rr_q = 0 gives icache priority, rr_q = 1 gives dcache priority.
  - If both requesters are eligible, the priority side wins.
  - If only one is eligible, it wins.
  - After any grant, rr_q points to the other source.
- A ready output is high only for the granted source while the slot can accept. Handshake occurs on `valid & ready`.
- Store count:
  - Increments when a dcache store is accepted into the slot.
  - Decrements when `mem_rsp_valid_i & mem_rsp_src_i & mem_rsp_is_store_i`.
  - If both occur in the same cycle, the count is unchanged.
  - A decrement at 0 saturates at 0 and is otherwise ignored.
- Responses are demultiplexed combinationally by mem_rsp_src_i to the icache or dcache outputs; the other side's valid stays 0.
  - Responses have no backpressure.
  - Data and TID pass through unmodified.

## Timing
- Reset values: mem_req_valid_o = 0, payload = 0, rr_q = 0, count = 0, stores_idle_o = 1, stall_cycles_o = 0.
- Ready outputs are combinational from valids, count, rr_q and mem_req_ready_i. They are 0 during reset.
- Request latency: accepted in cycle N, visible on mem_req_* in cycle N+1.
- Back-to-back throughput: 1 request per cycle when mem_req_ready_i is held high.
- Payload is stable while `mem_req_valid_o & !mem_req_ready_i`.
- Response latency: 0 cycles. The count updates on the next edge.
- Throttle lift: a store ack in cycle N at count == Max makes a waiting store eligible in cycle N+1.
- Reset mid-operation (asynchronous): clears the slot, count and rr_q immediately. Responses arriving after reset are still routed, and their store acks saturate at 0.

## Configuration
- WT_MEM_ARB_PERF_EN defined: stall_cycles_o is a 32-bit wrapping counter. It increments every cycle in which any requester valid is high and no request handshake occurs on the cache side.
- WT_MEM_ARB_PERF_EN undefined: no counter is synthesized, and stall_cycles_o is tied to 0.

## Test plan
- Both caches request continuously with mem_req_ready_i = 1: grants alternate I, D, I, D starting with icache after reset, and mem_req_valid_o is high every cycle from cycle 2.
- Eight dcache stores, no acks: 7 are issued and the 8th ready stays 0. One store ack makes the 8th accepted one cycle later. outstanding_stores_o shows 7, then 6, then 7.
- Hold mem_req_ready_i = 0 for 5 cycles with the slot full: payload is unchanged and both cache readies are 0. On release, the next grant occurs in the same cycle.
- Simultaneous store accept and store ack at count 3: count stays 3. A store ack at count 0: count stays 0 and stores_idle_o = 1.
- Responses with src = 0, TID 2, data 0xA5…A5 and src = 1, is_store = 0: data appears only on the icache or dcache outputs respectively, in the same cycle.
- Assert rst_ni low with the slot full and count 4: mem_req_valid_o drops without a clock edge, count = 0, and the first grant after reset goes to icache. With WT_MEM_ARB_PERF_EN, a 3-cycle blocked icache request gives stall_cycles_o = 3.

Source files
------------

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter merging icache refills and write-through dcache requests onto one memory
// request slot, with store throttling and response demux. Optional macro: WT_MEM_ARB_PERF_EN.
module wt_mem_req_arbiter #(
  parameter int unsigned PLEN                 = 34,
  parameter int unsigned TidWidth             = 2,
  parameter int unsigned MaxOutstandingStores = 7,
  localparam int unsigned CntWidth            = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                icache_req_valid_i,
  output logic                icache_req_ready_o,
  input  logic [PLEN-1:0]     icache_req_addr_i,
  input  logic [TidWidth-1:0] icache_req_tid_i,
  input  logic                dcache_req_valid_i,
  output logic                dcache_req_ready_o,
  input  logic                dcache_req_is_store_i,
  input  logic [PLEN-1:0]     dcache_req_addr_i,
  input  logic [63:0]         dcache_req_wdata_i,
  input  logic [TidWidth-1:0] dcache_req_tid_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_src_o,
  output logic                mem_req_is_store_o,
  output logic [PLEN-1:0]     mem_req_addr_o,
  output logic [63:0]         mem_req_wdata_o,
  output logic [TidWidth-1:0] mem_req_tid_o,
  input  logic                mem_rsp_valid_i,
  input  logic                mem_rsp_src_i,
  input  logic                mem_rsp_is_store_i,
  input  logic [TidWidth-1:0] mem_rsp_tid_i,
  input  logic [127:0]        mem_rsp_data_i,
  output logic                icache_rsp_valid_o,
  output logic [TidWidth-1:0] icache_rsp_tid_o,
  output logic [127:0]        icache_rsp_data_o,
  output logic                dcache_rsp_valid_o,
  output logic                dcache_rsp_is_store_o,
  output logic [TidWidth-1:0] dcache_rsp_tid_o,
  output logic [127:0]        dcache_rsp_data_o,
  output logic [CntWidth-1:0] outstanding_stores_o,
  output logic                stores_idle_o,
  output logic [31:0]         stall_cycles_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstandingStores);

  logic                valid_q, valid_d;
  logic                src_q, src_d;
  logic                is_store_q, is_store_d;
  logic [PLEN-1:0]     addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [TidWidth-1:0] tid_q, tid_d;
  logic                rr_q, rr_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic can_accept;
  logic i_elig, d_elig;
  logic grant_i, grant_d;
  logic i_acc, d_acc;
  logic store_inc, store_dec;

  assign can_accept = !valid_q || mem_req_ready_i;
  assign i_elig     = icache_req_valid_i;
  assign d_elig     = dcache_req_valid_i && (!dcache_req_is_store_i || (count_q < MaxCnt));

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_elig && d_elig) begin
      grant_i = !rr_q;
      grant_d = rr_q;
    end else begin
      grant_i = i_elig;
      grant_d = d_elig;
    end
  end

  // Readies are forced low while reset is asserted.
  assign icache_req_ready_o = rst_ni && grant_i && can_accept;
  assign dcache_req_ready_o = rst_ni && grant_d && can_accept;
  assign i_acc              = icache_req_valid_i && icache_req_ready_o;
  assign d_acc              = dcache_req_valid_i && dcache_req_ready_o;

  always_comb begin
    valid_d    = valid_q;
    src_d      = src_q;
    is_store_d = is_store_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tid_d      = tid_q;
    rr_d       = rr_q;
    if (i_acc) begin
      valid_d    = 1'b1;
      src_d      = 1'b0;
      is_store_d = 1'b0;
      addr_d     = icache_req_addr_i;
      wdata_d    = '0;
      tid_d      = icache_req_tid_i;
      rr_d       = 1'b1;
    end else if (d_acc) begin
      valid_d    = 1'b1;
      src_d      = 1'b1;
      is_store_d = dcache_req_is_store_i;
      addr_d     = dcache_req_addr_i;
      wdata_d    = dcache_req_wdata_i;
      tid_d      = dcache_req_tid_i;
      rr_d       = 1'b0;
    end else if (mem_req_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // An ack with nothing outstanding is ignored so the count saturates at zero.
  assign store_inc = d_acc && dcache_req_is_store_i;
  assign store_dec = mem_rsp_valid_i && mem_rsp_src_i && mem_rsp_is_store_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (store_inc && !store_dec) begin
      count_d = count_q + CntWidth'(1);
    end else if (!store_inc && store_dec) begin
      count_d = count_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      src_q      <= 1'b0;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tid_q      <= '0;
      rr_q       <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      src_q      <= src_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tid_q      <= tid_d;
      rr_q       <= rr_d;
      count_q    <= count_d;
    end
  end

  assign mem_req_valid_o      = valid_q;
  assign mem_req_src_o        = src_q;
  assign mem_req_is_store_o   = is_store_q;
  assign mem_req_addr_o       = addr_q;
  assign mem_req_wdata_o      = wdata_q;
  assign mem_req_tid_o        = tid_q;
  assign outstanding_stores_o = count_q;
  assign stores_idle_o        = (count_q == '0) && !(valid_q && is_store_q);

  always_comb begin
    icache_rsp_valid_o    = mem_rsp_valid_i && !mem_rsp_src_i;
    dcache_rsp_valid_o    = mem_rsp_valid_i && mem_rsp_src_i;
    icache_rsp_tid_o      = icache_rsp_valid_o ? mem_rsp_tid_i : '0;
    icache_rsp_data_o     = icache_rsp_valid_o ? mem_rsp_data_i : '0;
    dcache_rsp_tid_o      = dcache_rsp_valid_o ? mem_rsp_tid_i : '0;
    dcache_rsp_data_o     = dcache_rsp_valid_o ? mem_rsp_data_i : '0;
    dcache_rsp_is_store_o = dcache_rsp_valid_o && mem_rsp_is_store_i;
  end

`ifdef WT_MEM_ARB_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((icache_req_valid_i || dcache_req_valid_i) && !(i_acc || d_acc)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
